// File: rtl/locked_ckt_query_sequencer.sv
// Oracle query sequencer for a key-locked combinational netlist.
// Holds a serially loaded key, applies one PI pattern per query, waits a
// programmable settle time, captures the POs and returns them over a
// valid/ready response channel while counting completed queries.
module locked_ckt_query_sequencer #(
  parameter int unsigned PI_W   = 36,
  parameter int unsigned KEY_W  = 16,
  parameter int unsigned PO_W   = 7,
  parameter int unsigned SETTLE = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_bit_in,
  input  logic              key_shift_en,
  input  logic              key_commit,
  input  logic              key_zeroize,
  output logic [KEY_W-1:0]  key_out,
  output logic              key_valid,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [PI_W-1:0]   req_pattern,
  output logic [PI_W-1:0]   pi_out,
  input  logic [PO_W-1:0]   po_in,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [PO_W-1:0]   rsp_data,
  output logic              busy,
  output logic [15:0]       query_count
);

  if (SETTLE < 1 || SETTLE > 255) begin : g_bad_settle
    $error("SETTLE must be in 1..255");
  end

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_RESP} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [KEY_W-1:0] shadow;
  logic             commit_pending;
  logic [7:0]       cnt;
  logic             accept;
  logic             rsp_fire;

  assign req_ready = (state == S_IDLE) && key_valid && !commit_pending;
  assign accept    = req_valid && req_ready;
  assign rsp_fire  = (state == S_RESP) && rsp_valid && rsp_ready;
  assign busy      = (state != S_IDLE);

  // Next-state logic; zeroize aborts any query in flight.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (accept)     state_nxt = S_SETTLE;
      S_SETTLE: if (cnt == '0)  state_nxt = S_RESP;
      S_RESP:   if (rsp_fire)   state_nxt = S_IDLE;
      default:                  state_nxt = S_IDLE;
    endcase
    if (key_zeroize) state_nxt = S_IDLE;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Key shadow shifting and commit; a commit outside an idle, non-accepting
  // cycle is deferred so key_out stays frozen for the whole query.
  always_ff @(posedge clk) begin
    if (rst || key_zeroize) begin
      shadow         <= '0;
      key_out        <= '0;
      key_valid      <= 1'b0;
      commit_pending <= 1'b0;
    end else begin
      if (key_shift_en) shadow <= {shadow[KEY_W-2:0], key_bit_in};
      if ((state == S_IDLE) && !accept && (key_commit || commit_pending)) begin
        key_out        <= shadow;
        key_valid      <= 1'b1;
        commit_pending <= 1'b0;
      end else if (key_commit) begin
        commit_pending <= 1'b1;
      end
    end
  end

  // Query datapath: pattern launch, settle countdown, capture, count.
  always_ff @(posedge clk) begin
    if (rst) begin
      pi_out      <= '0;
      rsp_data    <= '0;
      rsp_valid   <= 1'b0;
      query_count <= '0;
      cnt         <= '0;
    end else if (key_zeroize) begin
      rsp_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            pi_out <= req_pattern;
            cnt    <= 8'(SETTLE - 1);
          end
        end
        S_SETTLE: begin
          if (cnt == '0) begin
            rsp_data  <= po_in;
            rsp_valid <= 1'b1;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        S_RESP: begin
          if (rsp_fire) begin
            rsp_valid <= 1'b0;
            if (query_count != '1) query_count <= query_count + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_locked_ckt_query_sequencer.sv
// Directed bench for locked_ckt_query_sequencer: key load/commit, query
// latency, response backpressure, deferred commit, zeroize, saturation, reset.
module tb_locked_ckt_query_sequencer;

  localparam int unsigned PI_W  = 36;
  localparam int unsigned KEY_W = 16;
  localparam int unsigned PO_W  = 7;

  localparam logic [PI_W-1:0] P1 = 36'h9_1234_5678; // po = 7'h30
  localparam logic [PI_W-1:0] P2 = 36'h0_0000_00FF; // po = 7'h7F
  localparam logic [PI_W-1:0] P3 = 36'hA_0000_0001; // po = 7'h51

  logic              clk = 1'b0;
  logic              rst;
  logic              key_bit_in, key_shift_en, key_commit, key_zeroize;
  logic [KEY_W-1:0]  key_out;
  logic              key_valid;
  logic              req_valid, req_ready;
  logic [PI_W-1:0]   req_pattern;
  logic [PI_W-1:0]   pi_out;
  logic [PO_W-1:0]   po_in;
  logic [PO_W-1:0]   po_mask;
  logic              rsp_valid, rsp_ready;
  logic [PO_W-1:0]   rsp_data;
  logic              busy;
  logic [15:0]       query_count;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  // Netlist stand-in: outputs are a fixed function of the applied pattern,
  // with an optional disturbance mask.
  assign po_in = pi_out[6:0] ^ pi_out[35:29] ^ po_mask;

  locked_ckt_query_sequencer #(
    .PI_W(PI_W), .KEY_W(KEY_W), .PO_W(PO_W), .SETTLE(2)
  ) dut (
    .clk(clk), .rst(rst),
    .key_bit_in(key_bit_in), .key_shift_en(key_shift_en),
    .key_commit(key_commit), .key_zeroize(key_zeroize),
    .key_out(key_out), .key_valid(key_valid),
    .req_valid(req_valid), .req_ready(req_ready), .req_pattern(req_pattern),
    .pi_out(pi_out), .po_in(po_in),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .busy(busy), .query_count(query_count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic shift_key(input logic [KEY_W-1:0] val);
    for (int i = KEY_W - 1; i >= 0; i--) begin
      key_shift_en = 1'b1;
      key_bit_in   = val[i];
      tick();
    end
    key_shift_en = 1'b0;
    key_bit_in   = 1'b0;
  endtask

  task automatic commit_key();
    key_commit = 1'b1;
    tick();
    key_commit = 1'b0;
  endtask

  // Full query with rsp_ready already high; fixed cycle schedule.
  task automatic run_query(input logic [PI_W-1:0] pat, input logic [PO_W-1:0] exp_po,
                           input logic [15:0] exp_cnt);
    check("rq_ready", req_ready, 1);
    req_pattern = pat;
    req_valid   = 1'b1;
    rsp_ready   = 1'b1;
    tick();
    req_valid = 1'b0;
    check("rq_busy", busy, 1);
    tick();
    tick();
    check("rq_rsp_valid", rsp_valid, 1);
    check("rq_rsp_data", rsp_data, exp_po);
    tick();
    rsp_ready = 1'b0;
    check("rq_done", rsp_valid, 0);
    check("rq_count", query_count, exp_cnt);
  endtask

  initial begin
    rst = 1'b1; key_bit_in = 0; key_shift_en = 0; key_commit = 0; key_zeroize = 0;
    req_valid = 0; req_pattern = '0; rsp_ready = 0; po_mask = '0;
    tick(); tick();
    check("rst_key_out", key_out, 0);
    check("rst_key_valid", key_valid, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_count", query_count, 0);
    check("rst_pi_out", pi_out, 0);
    rst = 1'b0;

    // Key load and commit.
    shift_key(16'hA5C3);
    check("pre_commit_key", key_out, 0);
    commit_key();
    check("key_out", key_out, 16'hA5C3);
    check("key_valid", key_valid, 1);
    check("req_ready", req_ready, 1);

    // Query 1 with 10 cycles of response backpressure.
    req_pattern = P1;
    req_valid   = 1'b1;
    tick();                                  // E0
    req_valid = 1'b0;
    check("q1_pi_out", pi_out, P1);
    check("q1_busy", busy, 1);
    check("q1_rdy_low", req_ready, 0);
    check("q1_e0_rsp", rsp_valid, 0);
    tick();                                  // E0+1
    check("q1_e1_rsp", rsp_valid, 0);
    tick();                                  // E0+2 capture
    check("q1_rsp_valid", rsp_valid, 1);
    check("q1_rsp_data", rsp_data, 7'h30);
    for (int i = 0; i < 10; i++) begin
      po_mask = po_mask ^ 7'h2A;
      tick();
      check("hold_data", rsp_data, 7'h30);
      check("hold_valid", rsp_valid, 1);
      check("hold_ready", req_ready, 0);
    end
    po_mask   = '0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("q1_rsp_clr", rsp_valid, 0);
    check("q1_count", query_count, 1);
    check("q1_idle", busy, 0);
    check("q1_ready", req_ready, 1);
    tick();
    check("q1_count_once", query_count, 1);
    check("q1_pi_hold", pi_out, P1);

    // Deferred commit: shift in IDLE, commit during SETTLE.
    shift_key(16'h0F0F);
    check("shift_no_disturb", key_out, 16'hA5C3);
    req_pattern = P2;
    req_valid   = 1'b1;
    tick();                                  // E0
    req_valid  = 1'b0;
    key_commit = 1'b1;
    tick();                                  // E0+1
    key_commit = 1'b0;
    check("dc_key_settle", key_out, 16'hA5C3);
    tick();                                  // E0+2
    check("dc_rsp_valid", rsp_valid, 1);
    check("dc_rsp_data", rsp_data, 7'h7F);
    check("dc_key_resp", key_out, 16'hA5C3);
    check("dc_ready_resp", req_ready, 0);
    rsp_ready = 1'b1;
    tick();                                  // handshake, back to IDLE
    rsp_ready = 1'b0;
    check("dc_idle", busy, 0);
    check("dc_key_pending", key_out, 16'hA5C3);
    check("dc_ready_pending", req_ready, 0);
    check("dc_count", query_count, 2);
    tick();                                  // first IDLE edge commits
    check("dc_key_new", key_out, 16'h0F0F);
    check("dc_ready_new", req_ready, 1);

    // Zeroize mid-SETTLE.
    req_pattern = P3;
    req_valid   = 1'b1;
    tick();
    req_valid   = 1'b0;
    key_zeroize = 1'b1;
    tick();
    key_zeroize = 1'b0;
    check("zz_busy", busy, 0);
    check("zz_rsp_valid", rsp_valid, 0);
    check("zz_key_out", key_out, 0);
    check("zz_key_valid", key_valid, 0);
    check("zz_ready", req_ready, 0);
    check("zz_count", query_count, 2);
    check("zz_pi_out", pi_out, P3);
    tick(); tick();
    check("zz_rsp_stays", rsp_valid, 0);

    // Saturation of the query counter.
    shift_key(16'hA5C3);
    commit_key();
    force dut.query_count = 16'hFFFE;
    tick();
    release dut.query_count;
    tick();
    check("sat_preset", query_count, 16'hFFFE);
    run_query(P1, 7'h30, 16'hFFFF);
    run_query(P2, 7'h7F, 16'hFFFF);
    run_query(P3, 7'h51, 16'hFFFF);

    // Reset in RESP.
    req_pattern = P2;
    req_valid   = 1'b1;
    tick();
    req_valid = 1'b0;
    tick(); tick();
    check("rr_in_resp", rsp_valid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rr_key_out", key_out, 0);
    check("rr_key_valid", key_valid, 0);
    check("rr_pi_out", pi_out, 0);
    check("rr_rsp_data", rsp_data, 0);
    check("rr_rsp_valid", rsp_valid, 0);
    check("rr_count", query_count, 0);
    check("rr_busy", busy, 0);
    check("rr_ready", req_ready, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
